// File: rtl/thinpad_pkg.sv
// thinpad_pkg: shared state, owner and NOP encodings for the pipeline controller
package thinpad_pkg;
    typedef enum logic [1:0] {IDLE, F_WAIT, D_WAIT} state_e;
    typedef enum logic {FETCH, DATA} owner_e;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
endpackage

// File: rtl/ram_access_seq.sv
// ram_access_seq: sequences single-port RAM accesses between fetch and data, drives RAM pins
module ram_access_seq
    import thinpad_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_data_oe,
    output logic        ram_oe_n,
    output logic        busy_o,
    output logic        final_o,
    output owner_e      owner_o,
    output logic        store_o,
    output logic        we_phase_o
);
    localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_WAIT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    owner_e        owner_q, owner_d;
    logic          we_q, we_d;
    logic [15:0]   addr_q, addr_d;
    logic          idle, store, last;
    logic [15:0]   addr;

    always_comb begin
        idle        = state_q == IDLE;
        owner_o     = idle ? (mem_req ? DATA : FETCH) : owner_q;
        store       = owner_o == DATA && (idle ? mem_we : we_q);
        addr        = idle ? (owner_o == DATA ? mem_addr : if_addr) : addr_q;
        last        = (MEM_WAIT == 0) ? idle : (!idle && cnt_q == LAST);
        final_o     = rst && last;
        busy_o      = rst && !last;
        store_o     = rst && store;
        ram_addr    = rst ? addr : if_addr;
        ram_wdata   = mem_wdata;
        ram_data_oe = store_o;
        ram_oe_n    = !(rst && !store);
        // write pulse only in the clk-high half so the address is set up half a cycle earlier
        we_phase_o  = final_o && store_o && clk;
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        if (MEM_WAIT != 0) begin
            if (idle) begin
                state_d = owner_o == DATA ? D_WAIT : F_WAIT;
                cnt_d   = CW'(1);
                owner_d = owner_o;
                we_d    = mem_we;
                addr_d  = addr;
            end else if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: shares the RAM port between IF and MEM and decodes stall/bubble/flush strobes
module pipe_ctrl
    import thinpad_pkg::*;
#(
    parameter int MEM_WAIT   = 0,
    parameter int DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_addr,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic [15:0] ram_rdata,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_data_oe,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic [15:0] fetch_instr,
    output logic [15:0] mem_rdata,
    output logic        mem_done,
    output logic        pc_keep,
    output logic        ifkeep,
    output logic        ifClear,
    output logic        idex_bubble,
    output logic        stall_all
);
    logic   busy, fin, store, we_phase;
    owner_e owner;

    ram_access_seq #(.MEM_WAIT(MEM_WAIT)) u_seq (
        .clk         (clk),
        .rst         (rst),
        .if_addr     (if_addr),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_data_oe (ram_data_oe),
        .ram_oe_n    (ram_oe_n),
        .busy_o      (busy),
        .final_o     (fin),
        .owner_o     (owner),
        .store_o     (store),
        .we_phase_o  (we_phase)
    );

    assign ram_we_n = !we_phase;

    always_comb begin
        fetch_instr = NOP_INSTR;
        mem_rdata   = '0;
        mem_done    = 1'b0;
        pc_keep     = 1'b0;
        ifkeep      = 1'b0;
        ifClear     = 1'b0;
        idex_bubble = 1'b0;
        stall_all   = 1'b0;
        if (busy) begin
            stall_all = 1'b1;
            pc_keep   = 1'b1;
            ifkeep    = 1'b1;
        end else if (fin && owner == DATA) begin
            // data stole this cycle's fetch slot: bubble IF/ID and re-fetch the same PC
            mem_done  = 1'b1;
            mem_rdata = store ? '0 : ram_rdata;
            pc_keep   = 1'b1;
            ifClear   = 1'b1;
        end else if (fin) begin
            fetch_instr = ram_rdata;
            if (load_use) begin
                pc_keep     = 1'b1;
                ifkeep      = 1'b1;
                idex_bubble = 1'b1;
            end else begin
                ifClear = branch_taken && DELAY_SLOT == 0;
            end
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus on two configurations, checked every half cycle against an access-level model
module tb_pipe_ctrl;
    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic [15:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, ram_rdata = '0;
    logic        mem_req = 1'b0, mem_we = 1'b0, load_use = 1'b0, branch_taken = 1'b0;

    logic [15:0] ram_addr [2], ram_wdata [2], fetch_instr [2], mem_rdata [2];
    logic        ram_data_oe [2], ram_oe_n [2], ram_we_n [2], mem_done [2];
    logic        pc_keep [2], ifkeep [2], ifClear [2], idex_bubble [2], stall_all [2];

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_WAIT(0), .DELAY_SLOT(0)) u0 (
        .clk(clk), .rst(rst), .if_addr(if_addr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .load_use(load_use), .branch_taken(branch_taken),
        .ram_rdata(ram_rdata), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
        .ram_data_oe(ram_data_oe[0]), .ram_oe_n(ram_oe_n[0]), .ram_we_n(ram_we_n[0]),
        .fetch_instr(fetch_instr[0]), .mem_rdata(mem_rdata[0]), .mem_done(mem_done[0]),
        .pc_keep(pc_keep[0]), .ifkeep(ifkeep[0]), .ifClear(ifClear[0]),
        .idex_bubble(idex_bubble[0]), .stall_all(stall_all[0])
    );

    pipe_ctrl #(.MEM_WAIT(2), .DELAY_SLOT(1)) u2 (
        .clk(clk), .rst(rst), .if_addr(if_addr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .load_use(load_use), .branch_taken(branch_taken),
        .ram_rdata(ram_rdata), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
        .ram_data_oe(ram_data_oe[1]), .ram_oe_n(ram_oe_n[1]), .ram_we_n(ram_we_n[1]),
        .fetch_instr(fetch_instr[1]), .mem_rdata(mem_rdata[1]), .mem_done(mem_done[1]),
        .pc_keep(pc_keep[1]), .ifkeep(ifkeep[1]), .ifClear(ifClear[1]),
        .idex_bubble(idex_bubble[1]), .stall_all(stall_all[1])
    );

    // model: each access lasts mw+1 cycles; its owner and address are fixed in its first cycle
    int          mw [2] = '{0, 2};
    int          ds [2] = '{0, 1};
    int          age [2] = '{0, 0};
    bit          lat_data [2], lat_we [2];
    logic [15:0] lat_addr [2];

    always @(negedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                age[i] <= 0;
            end else begin
                if (age[i] == 0) begin
                    lat_data[i] <= mem_req;
                    lat_we[i]   <= mem_we;
                    lat_addr[i] <= mem_req ? mem_addr : if_addr;
                end
                age[i] <= (age[i] == mw[i]) ? 0 : age[i] + 1;
            end
        end
    end

    typedef struct packed {
        logic [15:0] addr, wdata, finstr, rdata;
        logic        data_oe, oe_n, we_n, done;
        logic [4:0]  st;
    } exp_t;

    function automatic exp_t model(input int i, input bit hi);
        exp_t e;
        bit d, s, fin;
        e.wdata = mem_wdata;
        if (!rst) begin
            e.addr = if_addr; e.finstr = 16'h0800; e.rdata = '0;
            e.data_oe = 1'b0; e.oe_n = 1'b1; e.we_n = 1'b1; e.done = 1'b0; e.st = '0;
            return e;
        end
        d   = (age[i] == 0) ? mem_req : lat_data[i];
        s   = d && ((age[i] == 0) ? mem_we : lat_we[i]);
        fin = age[i] == mw[i];
        e.addr    = (age[i] == 0) ? (mem_req ? mem_addr : if_addr) : lat_addr[i];
        e.data_oe = s;
        e.oe_n    = s;
        e.we_n    = !(hi && fin && s);
        e.done    = fin && d;
        e.finstr  = (fin && !d) ? ram_rdata : 16'h0800;
        e.rdata   = (fin && d && !s) ? ram_rdata : 16'h0000;
        // st = {pc_keep, ifkeep, ifClear, idex_bubble, stall_all}
        if (!fin)          e.st = 5'b11001;
        else if (d)        e.st = 5'b10100;
        else if (load_use) e.st = 5'b11010;
        else if (branch_taken && ds[i] == 0) e.st = 5'b00100;
        else               e.st = 5'b00000;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    task automatic cmp_inst(input int i, input bit hi);
        exp_t  e;
        string p;
        e = model(i, hi);
        p = $sformatf("u%0d_%s", i, hi ? "hi" : "lo");
        cmp({p, ".ram_addr"}, 32'(ram_addr[i]), 32'(e.addr));
        cmp({p, ".ram_wdata"}, 32'(ram_wdata[i]), 32'(e.wdata));
        cmp({p, ".fetch_instr"}, 32'(fetch_instr[i]), 32'(e.finstr));
        cmp({p, ".mem_rdata"}, 32'(mem_rdata[i]), 32'(e.rdata));
        cmp({p, ".ram_data_oe"}, 32'(ram_data_oe[i]), 32'(e.data_oe));
        cmp({p, ".ram_oe_n"}, 32'(ram_oe_n[i]), 32'(e.oe_n));
        cmp({p, ".ram_we_n"}, 32'(ram_we_n[i]), 32'(e.we_n));
        cmp({p, ".mem_done"}, 32'(mem_done[i]), 32'(e.done));
        cmp({p, ".strobes"}, 32'({pc_keep[i], ifkeep[i], ifClear[i], idex_bubble[i], stall_all[i]}), 32'(e.st));
    endtask

    always @(posedge clk) begin
        #1;
        cmp_inst(0, 1'b1);
        cmp_inst(1, 1'b1);
    end

    always @(negedge clk) begin
        #3;
        cmp_inst(0, 1'b0);
        cmp_inst(1, 1'b0);
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic at_hi;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        step();
        rst = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; load_use = 1'b0; branch_taken = 1'b0;
        #2;
        cmp("rst.fetch_instr", 32'(fetch_instr[1]), 32'h0800);
        cmp("rst.ram_oe_n", 32'(ram_oe_n[1]), 32'h1);
        step();
        rst = 1'b1;
    endtask

    initial begin
        step();
        step();
        // fetch stream with MEM_WAIT=0, then a load request arriving during F_WAIT
        do_reset();
        ram_rdata = 16'h4F02;
        for (int k = 0; k < 4; k++) begin
            if_addr = 16'(k);
            at_hi();
            cmp("fetch.u0_instr", 32'(fetch_instr[0]), 32'h4F02);
            cmp("fetch.u0_oe_n", 32'(ram_oe_n[0]), 32'h0);
            step();
        end
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h1111; ram_rdata = 16'h5555;
        for (int k = 0; k < 4; k++) step();
        mem_req = 1'b0;
        step();
        // store, MEM_WAIT=0 single cycle; held three cycles for back-to-back stores
        do_reset();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h8000; mem_wdata = 16'h1234; if_addr = 16'h0010;
        #2;
        cmp("store.u0_we_n_lo", 32'(ram_we_n[0]), 32'h1);
        at_hi();
        cmp("store.u0_addr", 32'(ram_addr[0]), 32'h8000);
        cmp("store.u0_we_n_hi", 32'(ram_we_n[0]), 32'h0);
        cmp("store.u0_keep_clr_done", 32'({pc_keep[0], ifClear[0], mem_done[0]}), 32'h7);
        for (int k = 0; k < 3; k++) step();
        mem_req = 1'b0;
        step();
        step();
        // load with MEM_WAIT=2
        do_reset();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h9000; ram_rdata = 16'hBEEF;
        for (int c = 0; c < 3; c++) begin
            at_hi();
            if (c < 2) begin
                cmp("load.u2_stall_ifkeep", 32'({stall_all[1], ifkeep[1]}), 32'h3);
            end else begin
                cmp("load.u2_done", 32'(mem_done[1]), 32'h1);
                cmp("load.u2_rdata", 32'(mem_rdata[1]), 32'hBEEF);
                cmp("load.u2_ifClear", 32'(ifClear[1]), 32'h1);
            end
            step();
        end
        mem_req = 1'b0;
        step();
        // load_use beats branch_taken; branch alone per DELAY_SLOT
        do_reset();
        load_use = 1'b1; branch_taken = 1'b1; ram_rdata = 16'h2A2A;
        at_hi();
        cmp("lu.u0_keep_ifkeep_bub_clr", 32'({pc_keep[0], ifkeep[0], idex_bubble[0], ifClear[0]}), 32'hE);
        step();
        load_use = 1'b0;
        at_hi();
        cmp("br.u0_ifClear", 32'(ifClear[0]), 32'h1);
        step();
        at_hi();
        cmp("br.u2_no_strobes", 32'({pc_keep[1], ifkeep[1], ifClear[1], idex_bubble[1]}), 32'h0);
        cmp("br.u2_fetch_instr", 32'(fetch_instr[1]), 32'h2A2A);
        step();
        branch_taken = 1'b0;
        step();
        // reset during the final cycle of a MEM_WAIT=2 store
        do_reset();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'hA000; mem_wdata = 16'h5A5A; if_addr = 16'h0040;
        step();
        step();
        at_hi();
        cmp("rstmid.u2_we_n_before", 32'(ram_we_n[1]), 32'h0);
        rst = 1'b0;
        #1;
        cmp("rstmid.u2_we_n", 32'(ram_we_n[1]), 32'h1);
        cmp("rstmid.u2_data_oe", 32'(ram_data_oe[1]), 32'h0);
        cmp("rstmid.u2_addr", 32'(ram_addr[1]), 32'h0040);
        step();
        rst = 1'b1; mem_req = 1'b0;
        at_hi();
        cmp("rstmid.u2_oe_n", 32'(ram_oe_n[1]), 32'h0);
        cmp("rstmid.u2_addr_fetch", 32'(ram_addr[1]), 32'h0040);
        cmp("rstmid.u2_stall", 32'(stall_all[1]), 32'h1);
        for (int k = 0; k < 3; k++) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the 16-bit five-stage core. It shares the single SRAM port between instruction fetch (IF) and load/store (MEM), and sequences multi-cycle RAM accesses. It also generates every stall, bubble and flush strobe consumed by the PC register, the IF/ID register (`ifkeep`, `ifClear`), ID/EX and EX/MEM. It sits beside the pipeline registers and owns the RAM control pins.

## Interface
Parameters:
- `MEM_WAIT`, default 0: extra wait cycles per RAM access (0 gives a 1-cycle access).
- `DELAY_SLOT`, default 1: 1 means a taken branch keeps the IF instruction (delay slot); 0 means it flushes it.

Ports:
- `clk`  in  1  system clock; all state updates on the falling edge, the same edge as the pipeline registers.
- `rst`  in  1  asynchronous, active-low reset.
- `if_addr`  in  16  current PC.
- `mem_req`  in  1  the MEM-stage instruction needs RAM.
- `mem_we`  in  1  1 = store, 0 = load; valid with `mem_req`.
- `mem_addr`  in  16  data address.
- `mem_wdata`  in  16  store data.
- `load_use`  in  1  load-use hazard detected in ID.
- `branch_taken`  in  1  branch resolved taken in ID.
- `ram_rdata`  in  16  RAM read bus.
- `ram_addr`  out  16  RAM address.
- `ram_wdata`  out  16  RAM write data.
- `ram_data_oe`  out  1  drive the write bus.
- `ram_oe_n`  out  1  RAM output enable, active low.
- `ram_we_n`  out  1  RAM write enable, active low.
- `fetch_instr`  out  16  instruction to IF/ID `instr_in`.
- `mem_rdata`  out  16  load data to MEM/WB.
- `mem_done`  out  1  data access completes this cycle.
- `pc_keep`  out  1  hold PC.
- `ifkeep`  out  1  hold IF/ID.
- `ifClear`  out  1  load NOP into IF/ID.
- `idex_bubble`  out  1  load NOP into ID/EX.
- `stall_all`  out  1  freeze ID/EX, EX/MEM and MEM/WB.

## Operation
- FSM states: `IDLE`, `F_WAIT`, `D_WAIT`. Wait counter `cnt` is 0..`MEM_WAIT`.
- In `IDLE` the access owner is chosen combinationally every cycle:
  - DATA if `mem_req`=1, otherwise FETCH. Data always wins.
- Address mux: `ram_addr` = `mem_addr` when the owner is DATA, `if_addr` when FETCH. `ram_wdata` = `mem_wdata`.
- When `MEM_WAIT`=0, every access completes in its `IDLE` cycle and the FSM never leaves `IDLE`.
- When `MEM_WAIT`>0:
  - `IDLE` goes to `F_WAIT` or `D_WAIT` with `cnt`=1, latching the owner.
  - `cnt` increments each cycle; the final cycle is `cnt`=`MEM_WAIT`, then the FSM returns to `IDLE`.
  - The owner and `ram_addr` stay stable for the whole access.
- Non-final cycles of any access:
  - `stall_all`=1, `pc_keep`=1, `ifkeep`=1.
  - All other strobes are 0.
- Final cycle, DATA owner:
  - `mem_done`=1.
  - Loads: `mem_rdata`=`ram_rdata`.
  - `pc_keep`=1 and `ifClear`=1 (structural-hazard bubble into IF/ID). `ifkeep`=0. Later stages advance.
- Final cycle, FETCH owner: `fetch_instr`=`ram_rdata`. Then, in priority order:
  1. `load_use`: `pc_keep`=1, `ifkeep`=1, `idex_bubble`=1. `branch_taken` is ignored this cycle.
  2. `branch_taken` with `DELAY_SLOT`=0: `ifClear`=1.
  3. Otherwise no strobes are asserted and the pipeline advances.
- `ifkeep` and `ifClear` are never both 1.
- RAM strobes:
  - `ram_oe_n`=0 during every read cycle (fetch, or load).
  - Stores: `ram_data_oe`=1 for the whole access. `ram_we_n`=0 only while `clk` is high in the final cycle, i.e. the second half of a falling-edge-to-falling-edge cycle. The address is therefore set up half a cycle before `ram_we_n` falls.
- Back-to-back `mem_req` (consecutive loads/stores) is serviced back-to-back, inserting one IF bubble each. Fetch resumes as soon as `mem_req`=0.

## Timing
- Cycle boundary is the falling edge of `clk`. Strobes are combinational from the registered state, `cnt` and inputs, and must settle before the next falling edge.
- Access latency is `MEM_WAIT`+1 cycles; `mem_done` is a single-cycle pulse.
- While `rst`=0, asynchronously:
  - State `IDLE`, `cnt`=0.
  - `ram_oe_n`=1, `ram_we_n`=1, `ram_data_oe`=0.
  - All stall/flush strobes and `mem_done` are 0.
  - `fetch_instr`=0x0800 (NOP); `mem_rdata`=0.
  - `ram_addr` = `if_addr`.
- Reset mid-access aborts it immediately: `ram_we_n` goes high with no partial write pulse. The next access starts in `IDLE` after reset releases.
- A `mem_req` change during `F_WAIT` is ignored until the fetch completes. The data access then starts in the following `IDLE` cycle.
- `cnt` never exceeds `MEM_WAIT`; no wrap-around.

## Structure
- Shared package `thinpad_pkg`:
  - state encodings `IDLE`/`F_WAIT`/`D_WAIT`;
  - `NOP_INSTR` = 16'h0800;
  - the owner constants FETCH/DATA.
- Sub-module `ram_access_seq` holds the FSM, `cnt`, the owner latch, the address mux and the RAM strobes. It exports `busy`, `final`, `owner` and `we_phase`.
- `pipe_ctrl` keeps the stall/flush priority decode.

## Test plan
- `MEM_WAIT`=0, `mem_req`=0, `if_addr` stepping 0..3, RAM returns 0x4F02 → `fetch_instr`=0x4F02 each cycle, all strobes 0, `ram_oe_n`=0.
- `MEM_WAIT`=0, store `mem_addr`=0x8000, `mem_wdata`=0x1234 → for one cycle `ram_addr`=0x8000, `ram_we_n` low only in the clk-high half, `pc_keep`=1, `ifClear`=1, `mem_done`=1.
- `MEM_WAIT`=2, load at 0x9000 with RAM returning 0xBEEF → 2 cycles of `stall_all`=1 and `ifkeep`=1. Then `mem_done`=1, `mem_rdata`=0xBEEF, `ifClear`=1.
- `load_use`=1 together with `branch_taken`=1 in a fetch-final cycle, `DELAY_SLOT`=0 → `pc_keep`=1, `ifkeep`=1, `idex_bubble`=1, `ifClear`=0.
- `branch_taken`=1 alone → `ifClear`=1 when `DELAY_SLOT`=0; no strobes when `DELAY_SLOT`=1.
- `MEM_WAIT`=2, `rst` low during `D_WAIT` of a store → `ram_we_n`=1 and `ram_data_oe`=0 immediately. After release the FSM is in `IDLE` and the fetch resumes.
